// File: rtl/dot_hamming_engine_if.sv
// Handshake/operand bus for dot_hamming_engine.
//   slave  : the engine (takes operands and start_valid, returns results)
//   master : the producer/consumer side
// Signals: vector_a/vector_b (N elements of W bits), vector_c/vector_d (N bits),
// signed_mode, start_valid/start_ready, result_valid/result_ready,
// dot_result (ACC_W), xor_result (N), hamming (HD_W), busy.
interface dot_hamming_engine_if #(
  parameter int N = 10,
  parameter int W = 4
);
  localparam int ACC_W = 2*W + $clog2(N);
  localparam int HD_W  = $clog2(N+1);

  logic [N*W-1:0]   vector_a;
  logic [N*W-1:0]   vector_b;
  logic [N-1:0]     vector_c;
  logic [N-1:0]     vector_d;
  logic             signed_mode;
  logic             start_valid;
  logic             start_ready;
  logic             result_valid;
  logic             result_ready;
  logic [ACC_W-1:0] dot_result;
  logic [N-1:0]     xor_result;
  logic [HD_W-1:0]  hamming;
  logic             busy;

  modport master (
    output vector_a, vector_b, vector_c, vector_d, signed_mode, start_valid, result_ready,
    input  start_ready, result_valid, dot_result, xor_result, hamming, busy
  );

  modport slave (
    input  vector_a, vector_b, vector_c, vector_d, signed_mode, start_valid, result_ready,
    output start_ready, result_valid, dot_result, xor_result, hamming, busy
  );
endinterface

// File: rtl/dot_hamming_engine.sv
// Multi-cycle dot product + Hamming distance engine.
// Processes LANES elements per beat over N/LANES beats, then holds the result
// until the consumer takes it.
// Ports: clk, rst (async active-high), bus (dot_hamming_engine_if.slave).
module dot_hamming_engine #(
  parameter int N     = 10,
  parameter int W     = 4,
  parameter int LANES = 2,
  localparam int ACC_W = 2*W + $clog2(N),
  localparam int HD_W  = $clog2(N+1)
) (
  input  logic                clk,
  input  logic                rst,
  dot_hamming_engine_if.slave bus
);
  localparam int BEATS = N / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t r_state, w_next;
  logic   r_start_ready;

  logic [N*W-1:0]   r_a, r_b;
  logic [N-1:0]     r_c, r_d;
  logic             r_signed;
  logic [ACC_W-1:0] r_acc, r_dot, w_acc_nxt;
  logic [HD_W-1:0]  r_hd_cnt, r_hd, w_hd_nxt;
  logic [N-1:0]     r_xor, w_c_rot, w_d_rot;
  logic [CNT_W-1:0] r_beat;
  logic             w_last;

  logic [LANES-1:0][ACC_W-1:0] w_prod;
  logic [LANES-1:0]            w_xbit;

  assign w_last = (r_beat == CNT_W'(BEATS-1));

  // Lanes always read the low slice; operands shift down each beat.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [ACC_W-1:0] w_ea, w_eb;
    // Extend to ACC_W first; a modulo-2^ACC_W multiply is then correct
    // for both two's complement and unsigned operands.
    assign w_ea      = {{(ACC_W-W){r_signed & r_a[l*W+W-1]}}, r_a[l*W +: W]};
    assign w_eb      = {{(ACC_W-W){r_signed & r_b[l*W+W-1]}}, r_b[l*W +: W]};
    assign w_prod[l] = w_ea * w_eb;
    assign w_xbit[l] = r_c[l] ^ r_d[l];
  end

  always_comb begin
    w_acc_nxt = r_acc;
    w_hd_nxt  = r_hd_cnt;
    for (int l = 0; l < LANES; l++) begin
      w_acc_nxt = w_acc_nxt + w_prod[l];
      w_hd_nxt  = w_hd_nxt + HD_W'(w_xbit[l]);
    end
  end

  // C/D rotate rather than shift: after BEATS rotations by LANES they are
  // back to the captured values, which feed xor_result.
  assign w_c_rot = (r_c >> LANES) | (r_c << (N-LANES));
  assign w_d_rot = (r_d >> LANES) | (r_d << (N-LANES));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start_valid)  w_next = RUN;
      RUN:     if (w_last)           w_next = DONE;
      DONE:    if (bus.result_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_start_ready <= 1'b1;
    end else begin
      r_state       <= w_next;
      r_start_ready <= (w_next == IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_signed <= 1'b0;
      r_acc    <= '0;
      r_hd_cnt <= '0;
      r_beat   <= '0;
      r_dot    <= '0;
      r_hd     <= '0;
      r_xor    <= '0;
    end else if (r_state == IDLE && bus.start_valid) begin
      r_a      <= bus.vector_a;
      r_b      <= bus.vector_b;
      r_c      <= bus.vector_c;
      r_d      <= bus.vector_d;
      r_signed <= bus.signed_mode;
      r_acc    <= '0;
      r_hd_cnt <= '0;
      r_beat   <= '0;
    end else if (r_state == RUN) begin
      r_a      <= r_a >> (LANES*W);
      r_b      <= r_b >> (LANES*W);
      r_c      <= w_c_rot;
      r_d      <= w_d_rot;
      r_acc    <= w_acc_nxt;
      r_hd_cnt <= w_hd_nxt;
      r_beat   <= r_beat + 1'b1;
      if (w_last) begin
        r_dot <= w_acc_nxt;
        r_hd  <= w_hd_nxt;
        r_xor <= w_c_rot ^ w_d_rot;
      end
    end
  end

  assign bus.start_ready  = r_start_ready;
  assign bus.result_valid = (r_state == DONE);
  assign bus.busy         = (r_state != IDLE);
  assign bus.dot_result   = r_dot;
  assign bus.hamming      = r_hd;
  assign bus.xor_result   = r_xor;
endmodule

// File: doc/dot_hamming_engine.md
DOT_HAMMING_ENGINE -- requirements
Module: dot_hamming_engine

Interface
REQ-001 The block SHALL expose parameter N, default 10, giving the number of elements per vector.
REQ-002 The block SHALL expose parameter W, default 4, giving the bit width of each element.
REQ-003 The block SHALL expose parameter LANES, default 2, giving the number of elements processed per cycle; N MUST be a multiple of LANES.
REQ-004 The block SHALL expose derived parameters ACC_W = 2*W + clog2(N) (12 at defaults) and HD_W = clog2(N+1) (4 at defaults).
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 Port vector_a, input, N*W bits: element i is bits [W*i +: W].
REQ-008 Port vector_b, input, N*W bits: same layout as vector_a.
REQ-009 Port vector_c, input, N bits: binary vector.
REQ-010 Port vector_d, input, N bits: binary vector.
REQ-011 Port signed_mode, input, 1 bit: 1 means elements are two's complement, 0 means unsigned.
REQ-012 Port start_valid, input, 1 bit: operands and signed_mode are valid.
REQ-013 Port start_ready, output, 1 bit: the block can accept operands.
REQ-014 Port result_valid, output, 1 bit: the result outputs are valid.
REQ-015 Port result_ready, input, 1 bit: the consumer accepts the result.
REQ-016 Port dot_result, output, ACC_W bits: sum of element products, two's complement when signed_mode was 1.
REQ-017 Port xor_result, output, N bits: vector_c XOR vector_d.
REQ-018 Port hamming, output, HD_W bits: popcount of xor_result.
REQ-019 Port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-021 start_ready SHALL be 1 only in IDLE, and SHALL be a registered function of the state.
REQ-022 Accept: when start_valid and start_ready are both 1 at a clock edge, the block SHALL capture all four vectors and signed_mode into internal registers, clear the accumulator, the beat counter and the Hamming counter, and move to RUN.
REQ-023 Input changes after accept SHALL NOT affect the result in progress.
REQ-024 In RUN, each cycle SHALL process elements [b*LANES, b*LANES+LANES-1] for beat b = 0 .. N/LANES-1:
- add the W-bit products, sign-extended or zero-extended to ACC_W according to the captured mode, into the accumulator;
- add the popcount of the XOR bits for those elements into the Hamming counter.
REQ-025 Accumulation SHALL be modulo 2^ACC_W; ACC_W is sized so that no overflow occurs for any legal operands.
REQ-026 After the beat with b = N/LANES-1, the FSM SHALL enter DONE with result_valid = 1; the latency from the accept edge to result_valid high SHALL be exactly N/LANES cycles (5 at defaults).
REQ-027 When the FSM enters DONE, dot_result, hamming and xor_result SHALL be updated together.
REQ-028 In DONE, all result outputs SHALL be held stable until result_ready = 1 at a clock edge; the FSM then SHALL return to IDLE.
REQ-029 After the result handshake, result outputs SHALL keep their last values, and result_valid SHALL drop to 0.
REQ-030 start_valid SHALL be ignored in RUN and DONE; there SHALL be no same-cycle restart from DONE.
REQ-031 A result_ready pulse outside DONE SHALL have no effect.
REQ-032 When N/LANES = 1, RUN SHALL last one cycle and the latency SHALL be 1.

Reset
REQ-033 rst = 1 SHALL immediately force the state to IDLE and clear dot_result, xor_result, hamming, the accumulator and the counters to 0, regardless of the clock.
REQ-034 During reset, result_valid SHALL be 0, busy SHALL be 0 and start_ready SHALL be 1.
REQ-035 A reset asserted mid-RUN or in DONE SHALL discard the operation in progress; no result_valid SHALL follow it.
REQ-036 The first accept SHALL be possible on the first rising edge after rst is deasserted.

Verification
REQ-037 Unsigned: all A and B elements = 0xF, C = 10'h3FF, D = 0 -> after 5 cycles dot_result = 2250, xor_result = 10'h3FF, hamming = 10.
REQ-038 Signed: A elements = 0x8 (-8), B elements = 0x7, signed_mode = 1 -> dot_result = 12'hDD0 (-560); the same operands with signed_mode = 0 -> dot_result = 560.
REQ-039 Backpressure: hold result_ready = 0 for 3 cycles in DONE -> outputs stable, start_ready = 0, and start_valid ignored; result_ready = 1 -> IDLE on the next edge.
REQ-040 Mid-run reset: assert rst 2 cycles after accept -> all outputs 0 and IDLE; a new accept then yields a correct result with latency 5.
REQ-041 Operand hold: change vector_a on the cycle after accept -> the result reflects the captured operands; C = 10'b1010101010, D = 10'b0101010101 -> hamming = 10; C = D -> hamming = 0.
REQ-042 Sweep LANES = 1, 2, 5, 10 at N = 10 with random operands against a reference model; latency SHALL equal N/LANES.
